// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external combinational barrel shifter among NUM_REQ clients.
// Define SHIFT_ARBITER_ROTATE_EN to add req_rot and two-pass rotate support.
module shift_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_dir,
`ifdef SHIFT_ARBITER_ROTATE_EN
  input  logic [NUM_REQ-1:0]         req_rot,
`endif
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
  input  logic [NUM_REQ*DATA_W-1:0]  req_num,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       sh_control,
  output logic [SHAMT_W-1:0]         sh_shift,
  output logic [DATA_W-1:0]          sh_num,
  input  logic [DATA_W-1:0]          sh_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    RESP  = 2'd2
`ifdef SHIFT_ARBITER_ROTATE_EN
    , PASS2 = 2'd3
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                sh_control_q, sh_control_d;
  logic [SHAMT_W-1:0]  sh_shift_q, sh_shift_d;
  logic [DATA_W-1:0]   sh_num_q, sh_num_d;
`ifdef SHIFT_ARBITER_ROTATE_EN
  logic                rot_q, rot_d;
  logic [DATA_W-1:0]   tmp_q, tmp_d;
`endif

  logic [NUM_REQ-1:0]  req_ready_c;
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     scan_idx;

  logic [SHAMT_W-1:0]  shamt_arr [NUM_REQ];
  logic [DATA_W-1:0]   num_arr   [NUM_REQ];

  // Unpack the flattened per-requester operand buses.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign shamt_arr[i] = req_shamt[i*SHAMT_W +: SHAMT_W];
    assign num_arr[i]   = req_num[i*DATA_W +: DATA_W];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'(rr_ptr_q + ID_W'(k));
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    sh_control_d = sh_control_q;
    sh_shift_d   = sh_shift_q;
    sh_num_d     = sh_num_q;
`ifdef SHIFT_ARBITER_ROTATE_EN
    rot_d        = rot_q;
    tmp_d        = tmp_q;
`endif
    req_ready_c  = '0;

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_c[gnt_id] = 1'b1;
          sh_control_d        = req_dir[gnt_id];
          sh_shift_d          = shamt_arr[gnt_id];
          sh_num_d            = num_arr[gnt_id];
          resp_id_d           = gnt_id;
`ifdef SHIFT_ARBITER_ROTATE_EN
          // A zero-amount rotate is just a pass-through, so it stays single pass.
          rot_d               = req_rot[gnt_id] && (shamt_arr[gnt_id] != '0);
`endif
          state_d             = PASS1;
        end
      end

      PASS1: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
        if (rot_q) begin
          // Second pass shifts the opposite way by DATA_W-s; mod-2^SHAMT_W wrap gives it.
          tmp_d        = sh_out;
          sh_control_d = ~sh_control_q;
          sh_shift_d   = SHAMT_W'(DATA_W) - sh_shift_q;
          state_d      = PASS2;
        end else begin
          resp_data_d  = sh_out;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
`else
        resp_data_d  = sh_out;
        resp_valid_d = 1'b1;
        state_d      = RESP;
`endif
      end

`ifdef SHIFT_ARBITER_ROTATE_EN
      PASS2: begin
        resp_data_d  = tmp_q | sh_out;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
`endif

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = ID_W'(resp_id_q + 1'b1);
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      sh_control_q <= 1'b0;
      sh_shift_q   <= '0;
      sh_num_q     <= '0;
`ifdef SHIFT_ARBITER_ROTATE_EN
      rot_q        <= 1'b0;
      tmp_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      sh_control_q <= sh_control_d;
      sh_shift_q   <= sh_shift_d;
      sh_num_q     <= sh_num_d;
`ifdef SHIFT_ARBITER_ROTATE_EN
      rot_q        <= rot_d;
      tmp_q        <= tmp_d;
`endif
    end
  end

  // Grant is combinational; masking with rst_n keeps it low while reset is held.
  assign req_ready  = req_ready_c & {NUM_REQ{rst_n}};
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign sh_control = sh_control_q;
  assign sh_shift   = sh_shift_q;
  assign sh_num     = sh_num_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural shifter and a response scoreboard.
// Rotate cases are included when SHIFT_ARBITER_ROTATE_EN is defined.
module tb_shift_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_dir;
`ifdef SHIFT_ARBITER_ROTATE_EN
  logic [NUM_REQ-1:0]         req_rot;
`endif
  logic [NUM_REQ*SHAMT_W-1:0] req_shamt;
  logic [NUM_REQ*DATA_W-1:0]  req_num;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  logic [DATA_W-1:0]          resp_data;
  logic                       sh_control;
  logic [SHAMT_W-1:0]         sh_shift;
  logic [DATA_W-1:0]          sh_num;
  logic [DATA_W-1:0]          sh_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  shift_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dir    (req_dir),
`ifdef SHIFT_ARBITER_ROTATE_EN
    .req_rot    (req_rot),
`endif
    .req_shamt  (req_shamt),
    .req_num    (req_num),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .sh_control (sh_control),
    .sh_shift   (sh_shift),
    .sh_num     (sh_num),
    .sh_out     (sh_out)
  );

  // External shared shifter: 0 = logical left, 1 = logical right.
  assign sh_out = sh_control ? (sh_num >> sh_shift) : (sh_num << sh_shift);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result: rotate built from a doubled word, shifts from plain operators.
  function automatic logic [31:0] model(input logic dir, input logic rot,
                                        input logic [4:0] s, input logic [31:0] num);
    logic [63:0] dbl;
    logic [63:0] tmp;
    dbl = {num, num};
    if (rot) begin
      if (dir) begin
        tmp = dbl >> s;
        return tmp[31:0];
      end
      tmp = dbl << s;
      return tmp[63:32];
    end
    return dir ? (num >> s) : (num << s);
  endfunction

  task automatic drive_req(input int id, input logic dir, input logic rot,
                           input logic [4:0] s, input logic [31:0] num);
    req_dir[id]                    = dir;
    req_shamt[id*SHAMT_W +: SHAMT_W] = s;
    req_num[id*DATA_W +: DATA_W]     = num;
`ifdef SHIFT_ARBITER_ROTATE_EN
    req_rot[id] = rot;
`else
    if (rot) $display("note: rotate request ignored in this build");
`endif
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    int   n;
    n = sb.size();
    if (n == 0) begin
      chk({tag, "_sb_empty"}, 32'(n), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, 32'(resp_id), 32'(e.id));
      chk({tag, "_data"}, resp_data, e.data);
    end
  endtask

  // Lone request from requester id; checks grant, shifter operands, latency and result.
  task automatic single_op(input string tag, input int id, input logic dir, input logic rot,
                           input logic [4:0] s, input logic [31:0] num,
                           input logic [31:0] exp_data, input int lat);
    logic [NUM_REQ-1:0] onehot;
    exp_t e;
    onehot = '0;
    onehot[id] = 1'b1;
    @(negedge clk);
    drive_req(id, dir, rot, s, num);
    req_valid = onehot;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(onehot));
    e.id   = ID_W'(id);
    e.data = exp_data;
    sb.push_back(e);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = '0;
        drive_req(id, ~dir, 1'b0, 5'($urandom), $urandom);
        #1;
        chk({tag, "_sh_num"}, sh_num, num);
        chk({tag, "_sh_shift"}, 32'(sh_shift), 32'(s));
        chk({tag, "_sh_ctl"}, 32'(sh_control), 32'(dir));
      end
      chk({tag, "_early"}, 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    pop_check(tag);
    @(negedge clk);
    #1;
    chk({tag, "_done"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          grants;
    int          resps;
    int          gid;
    logic        d;
    logic [4:0]  s;
    logic [31:0] n;
    exp_t        e;
    logic [DATA_W-1:0] held_data;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_dir    = '0;
    req_shamt  = '0;
    req_num    = '0;
`ifdef SHIFT_ARBITER_ROTATE_EN
    req_rot    = '0;
`endif
    resp_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_sh_num", sh_num, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic shifts and zero shift amount
    single_op("l6",  0, 1'b0, 1'b0, 5'd6,  32'd127, 32'h0000_1FC0, 2);
    single_op("r6",  1, 1'b1, 1'b0, 5'd6,  32'd127, 32'h0000_0001, 2);
    single_op("l31", 2, 1'b0, 1'b0, 5'd31, 32'd127, 32'h8000_0000, 2);
    single_op("r31", 3, 1'b1, 1'b0, 5'd31, 32'd127, 32'h0000_0000, 2);
    single_op("z_l", 0, 1'b0, 1'b0, 5'd0,  32'd127, 32'h0000_007F, 2);
    single_op("z_r", 1, 1'b1, 1'b0, 5'd0,  32'd127, 32'h0000_007F, 2);
    for (int i = 0; i < 4; i++) begin
      gid = int'($urandom_range(0, 3));
      d   = 1'($urandom);
      s   = 5'($urandom);
      n   = $urandom;
      single_op("rand", gid, d, 1'b0, s, n, model(d, 1'b0, s, n), 2);
    end

    // Round-robin with all requesters continuously valid
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++)
      drive_req(i, 1'(i), 1'b0, 5'(i * 3 + 1), 32'hA5C3_0F01 + 32'(i) * 32'h1111);
    req_valid = '1;
    grants = 0;
    resps  = 0;
    for (int c = 0; c < 40 && resps < 6; c++) begin
      #1;
      if (req_ready != '0) begin
        gid = grants % NUM_REQ;
        chk("rr_grant", 32'(req_ready), 32'(1) << gid);
        e.id   = ID_W'(gid);
        e.data = model(1'(gid), 1'b0, 5'(gid * 3 + 1), 32'hA5C3_0F01 + 32'(gid) * 32'h1111);
        sb.push_back(e);
        grants++;
      end
      if (resp_valid) begin
        pop_check("rr");
        resps++;
      end
      @(negedge clk);
      if (grants >= 6) req_valid = '0;
    end
    chk("rr_resp_count", 32'(resps), 32'd6);

    // Backpressure: result held while resp_ready low, no grants meanwhile
    @(negedge clk);
    resp_ready = 1'b0;
    drive_req(2, 1'b0, 1'b0, 5'd8, 32'h00AB_CDEF);
    drive_req(1, 1'b1, 1'b0, 5'd1, 32'h0000_0010);
    req_valid = 4'b0100;
    #1;
    chk("bp_ready", 32'(req_ready), 32'b0100);
    e.id   = 2'd2;
    e.data = 32'hABCD_EF00;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("bp_pass1_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_valid", 32'(resp_valid), 32'd1);
    held_data = resp_data;
    chk("bp_first_data", held_data, 32'hABCD_EF00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_id", 32'(resp_id), 32'd2);
      chk("bp_hold_data", resp_data, held_data);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = '0;
    #1;
    pop_check("bp");
    @(negedge clk);
    #1;
    chk("bp_done", 32'(resp_valid), 32'd0);

    // Async reset during PASS1 drops the op and restarts arbitration at requester 0
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 5'd6, 32'd127);
    req_valid = 4'b0001;
    #1;
    chk("ar_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    #1;
    chk("ar_pass1_sh_num", sh_num, 32'd127);
    rst_n = 1'b0;
    #1;
    chk("ar_req_ready", 32'(req_ready), 32'd0);
    chk("ar_resp_valid", 32'(resp_valid), 32'd0);
    chk("ar_resp_id", 32'(resp_id), 32'd0);
    chk("ar_resp_data", resp_data, 32'd0);
    chk("ar_sh_control", 32'(sh_control), 32'd0);
    chk("ar_sh_shift", 32'(sh_shift), 32'd0);
    chk("ar_sh_num", sh_num, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(0, 1'b1, 1'b0, 5'd4, 32'hFFFF_0000);
    drive_req(3, 1'b0, 1'b0, 5'd1, 32'h0000_0001);
    req_valid = 4'b1001;
    #1;
    chk("ar_regrant", 32'(req_ready), 32'b0001);
    e.id   = 2'd0;
    e.data = 32'h0FFF_F000;
    sb.push_back(e);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("ar_valid", 32'(resp_valid), 32'd1);
    pop_check("ar");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("ar_no_replay", 32'(resp_valid), 32'd0);
    end

`ifdef SHIFT_ARBITER_ROTATE_EN
    // Two-pass rotates and the zero-amount single-pass rotate
    single_op("rotl", 0, 1'b0, 1'b1, 5'd4, 32'h1234_5678, 32'h2345_6781, 3);
    single_op("rotr", 0, 1'b1, 1'b1, 5'd4, 32'h1234_5678, 32'h8123_4567, 3);
    single_op("rot0", 2, 1'b1, 1'b1, 5'd0, 32'h1234_5678, 32'h1234_5678, 2);
    for (int i = 0; i < 3; i++) begin
      gid = int'($urandom_range(0, 3));
      d   = 1'($urandom);
      s   = 5'($urandom_range(1, 31));
      n   = $urandom;
      single_op("rot_rand", gid, d, 1'b1, s, n, model(d, 1'b1, s, n), 3);
    end
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
